cpu_bus_responder: RTL

//  Responder side of the CPU core's memory bus: accepts the address/mem_rw/data cycles issued by the

---
 rtl/cpu_bus_pkg.sv | 35 +++
 rtl/cpu_bus_responder_if.sv | 23 ++
 rtl/cpu_ram_2k.sv | 28 ++
 rtl/cpu_bus_responder.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus responder: address map, region and
// state encodings, and the address decoder used at request accept.
package cpu_bus_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;

    localparam logic [ADDR_W-1:0] RAM_END  = 16'h1FFF;
    localparam logic [ADDR_W-1:0] UNMAP_LO = 16'h4018;
    localparam logic [ADDR_W-1:0] UNMAP_HI = 16'h401F;

    typedef enum logic [1:0] {
        REG_RAM   = 2'd0,
        REG_EXT   = 2'd1,
        REG_UNMAP = 2'd2
    } region_e;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_EXT_WAIT = 1'b1
    } state_e;

    // Full 16-bit decode; everything outside RAM and the small hole is external.
    function automatic region_e decode_region(input logic [ADDR_W-1:0] addr);
        region_e r;
        if (addr <= RAM_END)
            r = REG_RAM;
        else if ((addr >= UNMAP_LO) && (addr <= UNMAP_HI))
            r = REG_UNMAP;
        else
            r = REG_EXT;
        return r;
    endfunction

endpackage

// File: rtl/cpu_bus_responder_if.sv
// CPU-side memory bus: request/address/data from the core, read data and
// ready back from the responder.
interface cpu_bus_responder_if;
    import cpu_bus_pkg::*;

    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              mem_rw;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              ready;

    modport master (
        output cpu_req, cpu_addr, mem_rw, cpu_wdata,
        input  cpu_rdata, ready
    );

    modport slave (
        input  cpu_req, cpu_addr, mem_rw, cpu_wdata,
        output cpu_rdata, ready
    );

endinterface

// File: rtl/cpu_ram_2k.sv
// Single-port synchronous work RAM with registered read data.
// Contents and read register are not reset.
module cpu_ram_2k
    import cpu_bus_pkg::*;
#(
    parameter int RAM_AW = 11
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [RAM_AW-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [2**RAM_AW];

    // Write on enabled write cycles, otherwise register the addressed byte.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we)
                mem[addr] <= wdata;
            else
                q <= mem[addr];
        end
    end

endmodule

// File: rtl/cpu_bus_responder.sv
// Memory bus responder: mirrored work RAM answered without stall, an
// external req/ack port for register/cartridge space with a timeout, and
// an open-bus value returned for unmapped reads and abandoned accesses.
module cpu_bus_responder
    import cpu_bus_pkg::*;
#(
    parameter int RAM_AW  = 11,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    cpu_bus_responder_if.slave bus,
    output logic              ext_req,
    output logic [ADDR_W-1:0] ext_addr,
    output logic              ext_we,
    output logic [DATA_W-1:0] ext_wdata,
    input  logic              ext_ack,
    input  logic [DATA_W-1:0] ext_rdata,
    output logic              timeout_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e            state_q;
    logic [TO_W-1:0]   cnt_q;
    logic              ram_rd_p1;
    logic [DATA_W-1:0] rdata_p1;
    logic [DATA_W-1:0] open_bus_q;
    logic [DATA_W-1:0] ram_q;

    region_e           region;
    logic              accept;
    logic              ram_en;
    logic              wr_accept;
    logic              unm_rd;
    logic              ext_accept;
    logic              ext_done;
    logic              ext_to;
    logic [DATA_W-1:0] open_bus_cur;

    // ---- accept / decode ----
    assign region     = decode_region(bus.cpu_addr);
    assign accept     = bus.cpu_req && (state_q == S_IDLE);
    assign ram_en     = accept && (region == REG_RAM);
    assign wr_accept  = accept && !bus.mem_rw;
    assign unm_rd     = accept && (region == REG_UNMAP) && bus.mem_rw;
    assign ext_accept = accept && (region == REG_EXT);
    assign ext_done   = (state_q == S_EXT_WAIT) && ext_ack;
    assign ext_to     = (state_q == S_EXT_WAIT) && !ext_ack && (cnt_q == TO_LAST);

    // A RAM read lands on ram_q one cycle after accept; it is the most
    // recent bus value until captured into the holding registers.
    assign open_bus_cur = ram_rd_p1 ? ram_q : open_bus_q;

    cpu_ram_2k #(
        .RAM_AW (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (!bus.mem_rw),
        .addr  (bus.cpu_addr[RAM_AW-1:0]),
        .wdata (bus.cpu_wdata),
        .q     (ram_q)
    );

    // ---- return stage (p1) ----
    assign bus.cpu_rdata = ram_rd_p1 ? ram_q : rdata_p1;
    assign bus.ready     = (state_q == S_IDLE);

    // Flag that the RAM read register holds this cycle's read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ram_rd_p1 <= 1'b0;
        else
            ram_rd_p1 <= ram_en && bus.mem_rw;
    end

    // Hold the last returned read value so it survives writes and idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata_p1 <= '0;
        else if (ext_done && !ext_we)
            rdata_p1 <= ext_rdata;
        else if ((ext_to && !ext_we) || unm_rd || ram_rd_p1)
            rdata_p1 <= open_bus_cur;
    end

    // Track the last value seen on the data bus; a newly accepted write
    // is later in program order than a RAM read completing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            open_bus_q <= '0;
        else if (ext_done && !ext_we)
            open_bus_q <= ext_rdata;
        else if (wr_accept)
            open_bus_q <= bus.cpu_wdata;
        else
            open_bus_q <= open_bus_cur;
    end

    // External access FSM: latch the request, wait for ack or give up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ext_req     <= 1'b0;
            ext_addr    <= '0;
            ext_we      <= 1'b0;
            ext_wdata   <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ext_accept) begin
                        state_q   <= S_EXT_WAIT;
                        cnt_q     <= '0;
                        ext_req   <= 1'b1;
                        ext_addr  <= bus.cpu_addr;
                        ext_we    <= !bus.mem_rw;
                        ext_wdata <= bus.cpu_wdata;
                    end
                end
                S_EXT_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (ext_done) begin
                        state_q <= S_IDLE;
                        ext_req <= 1'b0;
                    end else if (ext_to) begin
                        state_q     <= S_IDLE;
                        ext_req     <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ext_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
